// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: ALU operation codes, primary opcodes, R-type function codes.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'b0000,
        ALU_SRL  = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_SUB  = 4'b0011,
        ALU_AND  = 4'b0100,
        ALU_OR   = 4'b0101,
        ALU_XOR  = 4'b0110,
        ALU_NOR  = 4'b0111,
        ALU_SLT  = 4'b1010,
        ALU_SLTU = 4'b1011
    } aluop_t;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_ADDI  = 6'h08,
        OP_ADDIU = 6'h09,
        OP_SLTI  = 6'h0A,
        OP_SLTIU = 6'h0B,
        OP_ANDI  = 6'h0C,
        OP_ORI   = 6'h0D,
        OP_XORI  = 6'h0E,
        OP_LUI   = 6'h0F,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } opcode_t;

    typedef enum logic [5:0] {
        FN_SLL  = 6'h00,
        FN_SRL  = 6'h02,
        FN_SLLV = 6'h04,
        FN_SRLV = 6'h06,
        FN_ADD  = 6'h20,
        FN_ADDU = 6'h21,
        FN_SUB  = 6'h22,
        FN_SUBU = 6'h23,
        FN_AND  = 6'h24,
        FN_OR   = 6'h25,
        FN_XOR  = 6'h26,
        FN_NOR  = 6'h27,
        FN_SLT  = 6'h2A,
        FN_SLTU = 6'h2B
    } funct_t;

    function automatic word_t sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/alu_if.sv
// Combinational ALU connection: operation and operands in, result and status flags out.
interface alu_if;
    cpu_types_pkg::aluop_t aluop;
    cpu_types_pkg::word_t  port_a;
    cpu_types_pkg::word_t  port_b;
    cpu_types_pkg::word_t  result;
    logic                  zero;
    logic                  negative;
    logic                  overflow;

    modport initiator (output aluop, port_a, port_b, input result, zero, negative, overflow);
    modport target    (input aluop, port_a, port_b, output result, zero, negative, overflow);
endinterface

// File: rtl/ex_alu_issue_alu.sv
// Combinational 32-bit ALU; shift amount comes from port_a[4:0], port_b is the shifted value.
module alu
    import cpu_types_pkg::*;
(
    alu_if.target bus
);
    word_t res;
    logic  ovf;

    always_comb begin
        res = '0;
        ovf = 1'b0;
        case (bus.aluop)
            ALU_SLL:  res = bus.port_b << bus.port_a[4:0];
            ALU_SRL:  res = bus.port_b >> bus.port_a[4:0];
            ALU_ADD: begin
                res = bus.port_a + bus.port_b;
                ovf = (bus.port_a[31] == bus.port_b[31]) && (res[31] != bus.port_a[31]);
            end
            ALU_SUB: begin
                res = bus.port_a - bus.port_b;
                ovf = (bus.port_a[31] != bus.port_b[31]) && (res[31] != bus.port_a[31]);
            end
            ALU_AND:  res = bus.port_a & bus.port_b;
            ALU_OR:   res = bus.port_a | bus.port_b;
            ALU_XOR:  res = bus.port_a ^ bus.port_b;
            ALU_NOR:  res = ~(bus.port_a | bus.port_b);
            ALU_SLT:  res = {31'b0, ($signed(bus.port_a) < $signed(bus.port_b))};
            ALU_SLTU: res = {31'b0, (bus.port_a < bus.port_b)};
            default:  res = '0;
        endcase
    end

    assign bus.result   = res;
    assign bus.zero     = (res == '0);
    assign bus.negative = res[31];
    assign bus.overflow = ovf;
endmodule

// File: rtl/ex_alu_issue.sv
// Execute-stage issue unit: decodes the instruction, drives the ALU and holds the EX/MEM latch.
module ex_alu_issue
    import cpu_types_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter bit          OVF_TRAP = 1'b1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    input  logic [4:0]        shamt,
    input  logic [15:0]       imm16,
    input  logic [4:0]        rt_addr,
    input  logic [4:0]        rd_addr,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic              flush,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [DATA_W-1:0] ex_result,
    output logic              ex_zero,
    output logic              ex_negative,
    output logic              ex_ovf_exc,
    output logic              ex_illegal,
    output logic              ex_wen,
    output logic [4:0]        ex_wsel
);
    aluop_t     aluop;
    word_t      port_a;
    word_t      port_b;
    logic       wen_dec;
    logic       trap_op;
    logic       illegal;
    logic [4:0] wsel_dec;
    logic       ovf_hit;
    logic       capture;

    alu_if alu_bus ();
    alu u_alu (.bus(alu_bus.target));

    assign alu_bus.aluop  = aluop;
    assign alu_bus.port_a = port_a;
    assign alu_bus.port_b = port_b;

    always_comb begin
        aluop    = ALU_ADD;
        port_a   = rs_data;
        port_b   = rt_data;
        wen_dec  = 1'b1;
        trap_op  = 1'b0;
        illegal  = 1'b0;
        wsel_dec = rt_addr;
        case (opcode)
            OP_RTYPE: begin
                wsel_dec = rd_addr;
                case (funct)
                    FN_SLL:  begin aluop = ALU_SLL; port_a = {27'b0, shamt}; end
                    FN_SRL:  begin aluop = ALU_SRL; port_a = {27'b0, shamt}; end
                    FN_SLLV: aluop = ALU_SLL;
                    FN_SRLV: aluop = ALU_SRL;
                    FN_ADD:  begin aluop = ALU_ADD; trap_op = 1'b1; end
                    FN_ADDU: aluop = ALU_ADD;
                    FN_SUB:  begin aluop = ALU_SUB; trap_op = 1'b1; end
                    FN_SUBU: aluop = ALU_SUB;
                    FN_AND:  aluop = ALU_AND;
                    FN_OR:   aluop = ALU_OR;
                    FN_XOR:  aluop = ALU_XOR;
                    FN_NOR:  aluop = ALU_NOR;
                    FN_SLT:  aluop = ALU_SLT;
                    FN_SLTU: aluop = ALU_SLTU;
                    default: illegal = 1'b1;
                endcase
            end
            OP_ADDI:  begin aluop = ALU_ADD;  port_b = sext16(imm16); trap_op = 1'b1; end
            OP_ADDIU: begin aluop = ALU_ADD;  port_b = sext16(imm16); end
            OP_SLTI:  begin aluop = ALU_SLT;  port_b = sext16(imm16); end
            OP_SLTIU: begin aluop = ALU_SLTU; port_b = sext16(imm16); end
            OP_ANDI:  begin aluop = ALU_AND;  port_b = {16'b0, imm16}; end
            OP_ORI:   begin aluop = ALU_OR;   port_b = {16'b0, imm16}; end
            OP_XORI:  begin aluop = ALU_XOR;  port_b = {16'b0, imm16}; end
            OP_LUI:   begin aluop = ALU_SLL;  port_a = 32'd16; port_b = {16'b0, imm16}; end
            OP_LW:    begin aluop = ALU_ADD;  port_b = sext16(imm16); end
            OP_SW:    begin aluop = ALU_ADD;  port_b = sext16(imm16); wen_dec = 1'b0; end
            OP_BEQ, OP_BNE: begin aluop = ALU_SUB; wen_dec = 1'b0; end
            default:  illegal = 1'b1;
        endcase
        if (illegal) begin
            wen_dec = 1'b0;
        end
    end

    assign ovf_hit  = OVF_TRAP && trap_op && alu_bus.overflow;
    assign id_ready = !ex_valid || ex_ready;
    assign capture  = id_valid && id_ready && !flush;

    // capture already excludes flush, so a flush or a plain drain falls through to the clear branch
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ex_valid    <= 1'b0;
            ex_result   <= '0;
            ex_zero     <= 1'b0;
            ex_negative <= 1'b0;
            ex_ovf_exc  <= 1'b0;
            ex_illegal  <= 1'b0;
            ex_wen      <= 1'b0;
            ex_wsel     <= '0;
        end else if (capture) begin
            ex_valid    <= 1'b1;
            ex_result   <= illegal ? '0 : alu_bus.result;
            ex_zero     <= illegal ? 1'b1 : alu_bus.zero;
            ex_negative <= illegal ? 1'b0 : alu_bus.negative;
            ex_ovf_exc  <= ovf_hit;
            ex_illegal  <= illegal;
            ex_wen      <= wen_dec && !ovf_hit;
            ex_wsel     <= wsel_dec;
        end else if (flush || ex_ready) begin
            ex_valid    <= 1'b0;
            ex_ovf_exc  <= 1'b0;
            ex_illegal  <= 1'b0;
            ex_wen      <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ex_alu_issue.sv
// Directed and randomized checks of ex_alu_issue against an instruction-level reference model.
module tb_ex_alu_issue;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic [4:0]  shamt;
        logic [15:0] imm;
        logic [4:0]  rt_addr;
        logic [4:0]  rd_addr;
        logic [31:0] rs;
        logic [31:0] rt;
    } instr_t;

    typedef struct packed {
        logic [31:0] result;
        logic        zero;
        logic        neg;
        logic        ovf;
        logic        ill;
        logic        wen;
        logic [4:0]  wsel;
    } exp_t;

    localparam longint MAXI = 64'sd2147483647;
    localparam longint MINI = -64'sd2147483648;

    logic        CLK = 1'b0;
    logic        RST;
    logic        id_valid, id_ready, flush, ex_valid, ex_ready;
    logic [5:0]  opcode, funct;
    logic [4:0]  shamt, rt_addr, rd_addr, ex_wsel;
    logic [15:0] imm16;
    logic [31:0] rs_data, rt_data, ex_result;
    logic        ex_zero, ex_negative, ex_ovf_exc, ex_illegal, ex_wen;

    int   tests = 0;
    int   fails = 0;
    logic m_valid = 1'b0;
    exp_t m_out;

    always #5 CLK = ~CLK;

    ex_alu_issue #(.DATA_W(32), .OVF_TRAP(1'b1)) dut (
        .CLK(CLK), .RST(RST), .id_valid(id_valid), .id_ready(id_ready),
        .opcode(opcode), .funct(funct), .shamt(shamt), .imm16(imm16),
        .rt_addr(rt_addr), .rd_addr(rd_addr), .rs_data(rs_data), .rt_data(rt_data),
        .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_result(ex_result),
        .ex_zero(ex_zero), .ex_negative(ex_negative), .ex_ovf_exc(ex_ovf_exc),
        .ex_illegal(ex_illegal), .ex_wen(ex_wen), .ex_wsel(ex_wsel)
    );

    function automatic instr_t mk(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                                  input logic [15:0] im, input logic [4:0] rta, input logic [4:0] rda,
                                  input logic [31:0] rs, input logic [31:0] rt);
        instr_t i;
        i.opcode = op; i.funct = fn; i.shamt = sh; i.imm = im;
        i.rt_addr = rta; i.rd_addr = rda; i.rs = rs; i.rt = rt;
        return i;
    endfunction

    function automatic exp_t ref_model(input instr_t i);
        exp_t        e;
        logic [31:0] a, b, simm, zimm, r;
        longint      wide;
        logic        trap, ill, wr;
        logic [4:0]  dst;
        a = i.rs; b = i.rt;
        simm = {{16{i.imm[15]}}, i.imm};
        zimm = {16'h0, i.imm};
        r = 32'h0; trap = 1'b0; ill = 1'b0; wr = 1'b1; dst = i.rt_addr; wide = 0;
        case (i.opcode)
            6'h00: begin
                dst = i.rd_addr;
                case (i.funct)
                    6'h00: r = b << i.shamt;
                    6'h02: r = b >> i.shamt;
                    6'h04: r = b << a[4:0];
                    6'h06: r = b >> a[4:0];
                    6'h20: begin
                        wide = longint'($signed(a)) + longint'($signed(b));
                        r = wide[31:0]; trap = (wide > MAXI) || (wide < MINI);
                    end
                    6'h21: r = a + b;
                    6'h22: begin
                        wide = longint'($signed(a)) - longint'($signed(b));
                        r = wide[31:0]; trap = (wide > MAXI) || (wide < MINI);
                    end
                    6'h23: r = a - b;
                    6'h24: r = a & b;
                    6'h25: r = a | b;
                    6'h26: r = a ^ b;
                    6'h27: r = ~(a | b);
                    6'h2A: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    6'h2B: r = (a < b) ? 32'd1 : 32'd0;
                    default: ill = 1'b1;
                endcase
            end
            6'h08: begin
                wide = longint'($signed(a)) + longint'($signed(simm));
                r = wide[31:0]; trap = (wide > MAXI) || (wide < MINI);
            end
            6'h09: r = a + simm;
            6'h0A: r = ($signed(a) < $signed(simm)) ? 32'd1 : 32'd0;
            6'h0B: r = (a < simm) ? 32'd1 : 32'd0;
            6'h0C: r = a & zimm;
            6'h0D: r = a | zimm;
            6'h0E: r = a ^ zimm;
            6'h0F: r = {i.imm, 16'h0};
            6'h23: r = a + simm;
            6'h2B: begin r = a + simm; wr = 1'b0; end
            6'h04, 6'h05: begin r = a - b; wr = 1'b0; end
            default: ill = 1'b1;
        endcase
        if (ill) begin
            r = 32'h0; wr = 1'b0; trap = 1'b0;
        end
        e.result = r; e.zero = (r == 32'h0); e.neg = r[31];
        e.ovf = trap; e.ill = ill; e.wen = wr && !trap; e.wsel = dst;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check("ex_valid", ex_valid, m_valid);
        check("ex_wen", ex_wen, m_valid ? m_out.wen : 1'b0);
        check("ex_ovf_exc", ex_ovf_exc, m_valid ? m_out.ovf : 1'b0);
        check("ex_illegal", ex_illegal, m_valid ? m_out.ill : 1'b0);
        if (m_valid) begin
            check("ex_result", ex_result, m_out.result);
            check("ex_zero", ex_zero, m_out.zero);
            check("ex_negative", ex_negative, m_out.neg);
            if (!m_out.ill) check("ex_wsel", ex_wsel, m_out.wsel);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_valid"}, ex_valid, 1'b0);
        check({tag, "_result"}, ex_result, 32'h0);
        check({tag, "_zero"}, ex_zero, 1'b0);
        check({tag, "_neg"}, ex_negative, 1'b0);
        check({tag, "_ovf"}, ex_ovf_exc, 1'b0);
        check({tag, "_ill"}, ex_illegal, 1'b0);
        check({tag, "_wen"}, ex_wen, 1'b0);
        check({tag, "_wsel"}, ex_wsel, 5'd0);
        check({tag, "_id_ready"}, id_ready, 1'b1);
    endtask

    // One clock: apply inputs, check id_ready, update the model, then check the latch after the edge.
    task automatic cycle(input logic v, input logic rdy, input logic fl, input instr_t in);
        id_valid = v; ex_ready = rdy; flush = fl;
        opcode = in.opcode; funct = in.funct; shamt = in.shamt; imm16 = in.imm;
        rt_addr = in.rt_addr; rd_addr = in.rd_addr; rs_data = in.rs; rt_data = in.rt;
        #1;
        check("id_ready", id_ready, !m_valid || rdy);
        if (fl) m_valid = 1'b0;
        else if (v && (!m_valid || rdy)) begin
            m_valid = 1'b1;
            m_out = ref_model(in);
        end else if (rdy) m_valid = 1'b0;
        @(posedge CLK);
        #1;
        check_outputs();
    endtask

    function automatic instr_t rand_instr();
        logic [11:0] ops [0:22];
        logic [11:0] pick;
        instr_t      i;
        int unsigned k;
        ops = '{12'h000, 12'h002, 12'h004, 12'h006, 12'h020, 12'h021, 12'h022, 12'h023,
                12'h024, 12'h025, 12'h026, 12'h027, 12'h02A, 12'h02B, 12'h200, 12'h240,
                12'h280, 12'h2C0, 12'h300, 12'h340, 12'h380, 12'h3C0, 12'hAC0};
        k = $urandom_range(0, 25);
        if (k < 23) pick = ops[k];
        else if (k == 23) pick = {6'h3F, 6'h00};
        else if (k == 24) pick = {6'h00, 6'h3E};
        else pick = {6'h10, 6'h20};
        i.opcode = pick[11:6];
        if (k >= 14 && k < 23) i.funct = 6'($urandom);
        else i.funct = pick[5:0];
        if ($urandom_range(0, 6) == 0) i.opcode = ($urandom_range(0, 1) == 0) ? 6'h04 : 6'h2B;
        i.shamt = 5'($urandom); i.imm = 16'($urandom);
        i.rt_addr = 5'($urandom); i.rd_addr = 5'($urandom);
        case ($urandom_range(0, 3))
            0: i.rs = 32'h7FFFFFFF;
            1: i.rs = 32'h80000000;
            default: i.rs = $urandom;
        endcase
        i.rt = ($urandom_range(0, 4) == 0) ? i.rs : $urandom;
        return i;
    endfunction

    initial begin
        instr_t ins;
        RST = 1'b1; id_valid = 1'b0; ex_ready = 1'b0; flush = 1'b0;
        opcode = '0; funct = '0; shamt = '0; imm16 = '0; rt_addr = '0; rd_addr = '0;
        rs_data = '0; rt_data = '0;
        repeat (2) @(posedge CLK);
        #1;
        check_reset("rst");
        RST = 1'b0;

        cycle(1, 1, 0, mk(6'h00, 6'h20, 0, 16'h0, 5'd2, 5'd3, 32'h7FFFFFFF, 32'h1));
        check("add_ovf_result", ex_result, 32'h80000000);
        check("add_ovf_exc", ex_ovf_exc, 1'b1);
        check("add_ovf_wen", ex_wen, 1'b0);
        cycle(1, 1, 0, mk(6'h00, 6'h21, 0, 16'h0, 5'd2, 5'd3, 32'h7FFFFFFF, 32'h1));
        check("addu_exc", ex_ovf_exc, 1'b0);
        check("addu_wen", ex_wen, 1'b1);
        cycle(1, 1, 0, mk(6'h00, 6'h00, 5'd4, 16'h0, 5'd1, 5'd5, 32'h0, 32'h0000000F));
        check("sll_result", ex_result, 32'h000000F0);
        cycle(1, 1, 0, mk(6'h0F, 6'h00, 0, 16'h1234, 5'd9, 5'd0, 32'hDEADBEEF, 32'h0));
        check("lui_result", ex_result, 32'h12340000);
        check("lui_wsel", ex_wsel, 5'd9);
        cycle(1, 1, 0, mk(6'h0A, 6'h00, 0, 16'h0001, 5'd4, 5'd0, 32'hFFFFFFFF, 32'h0));
        check("slti_result", ex_result, 32'h1);
        cycle(1, 1, 0, mk(6'h0B, 6'h00, 0, 16'hFFFF, 5'd4, 5'd0, 32'hFFFFFFFF, 32'h0));
        check("sltiu_result", ex_result, 32'h0);
        cycle(1, 1, 0, mk(6'h0D, 6'h00, 0, 16'h8000, 5'd6, 5'd0, 32'h0, 32'h0));
        check("ori_result", ex_result, 32'h00008000);

        // backpressure: three stalled cycles with a new instruction waiting, then release
        cycle(1, 1, 0, mk(6'h08, 6'h00, 0, 16'hFFFE, 5'd7, 5'd0, 32'h5, 32'h0));
        ins = mk(6'h00, 6'h24, 0, 16'h0, 5'd1, 5'd8, 32'hF0F0F0F0, 32'hFF00FF00);
        for (int n = 0; n < 3; n++) begin
            cycle(1, 0, 0, ins);
            check("stall_hold_result", ex_result, 32'h3);
        end
        cycle(1, 1, 0, ins);
        check("release_result", ex_result, 32'hF000F000);

        cycle(1, 0, 1, mk(6'h00, 6'h25, 0, 16'h0, 5'd1, 5'd2, 32'h1, 32'h2));
        check("flush_valid", ex_valid, 1'b0);
        cycle(1, 1, 0, mk(6'h04, 6'h00, 0, 16'h0010, 5'd3, 5'd0, 32'h1234ABCD, 32'h1234ABCD));
        check("beq_zero", ex_zero, 1'b1);
        check("beq_wen", ex_wen, 1'b0);
        cycle(1, 1, 0, mk(6'h3F, 6'h00, 0, 16'h0, 5'd3, 5'd0, 32'h11111111, 32'h22222222));
        check("illegal_flag", ex_illegal, 1'b1);
        check("illegal_result", ex_result, 32'h0);
        cycle(0, 1, 0, mk(6'h00, 6'h00, 0, 16'h0, 5'd0, 5'd0, 32'h0, 32'h0));

        // reset asserted mid-stall clears the latch without waiting for a clock edge
        cycle(1, 1, 0, mk(6'h00, 6'h22, 0, 16'h0, 5'd1, 5'd9, 32'h80000000, 32'h1));
        cycle(1, 0, 0, mk(6'h09, 6'h00, 0, 16'h0003, 5'd1, 5'd0, 32'h1, 32'h0));
        RST = 1'b1;
        #1;
        check_reset("rst_mid");
        @(posedge CLK);
        #1;
        RST = 1'b0;
        m_valid = 1'b0;
        cycle(1, 1, 0, mk(6'h09, 6'h00, 0, 16'h0003, 5'd1, 5'd0, 32'h1, 32'h0));
        check("post_rst_capture", ex_result, 32'h4);

        for (int n = 0; n < 300; n++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 15) == 0, rand_instr());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
